// File: rtl/uart1_rx.sv
// UART1 serial receiver: 8 data bits LSB first, even parity, one stop bit, idle high.
// Each bit is sampled mid-period; the byte is delivered with a one-cycle valid pulse and status flags.
module uart1_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int C  = CLKS_PER_BIT;
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(C - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          p_rx;
  logic          s1;
  logic          rx_s;

  // Two-flop synchronizer; both stages reset to the idle (high) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      p_rx       <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            p_rx  <= rx_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt        <= '0;
            data_out   <= shift_reg;
            parity_err <= p_rx ^ (^shift_reg);
            frame_err  <= ~rx_s;
            data_valid <= 1'b1;
            state      <= rx_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // A low stop bit means a held-low line; wait for idle before hunting for a start.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: doc/uart1_rx.md
# uart1_rx

Serial receiver paired with the UART1 transmitter; it consumes the `tx1` line and turns it back into bytes. The frame format is 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (`^data`), and 1 stop bit (1), idle-high. The receiver synchronizes the line, detects the start edge and samples each bit at mid-period. It delivers the byte with a one-cycle valid pulse plus parity and framing status.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be even and ≥4. Set to match the transmitter's bit period.
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- rx  input  1  serial line (UART1 `tx1`), asynchronous to clk, idle high
- data_out  output  8  last received byte, held until the next frame completes
- data_valid  output  1  one-cycle pulse when data_out/flags update
- parity_err  output  1  received parity ≠ ^data_out; valid with data_valid, held
- frame_err  output  1  stop bit sampled 0; valid with data_valid, held
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Synchronizer: two flops, rx → s1 → rx_s. Both flops reset to 1. All decisions use rx_s only.
- Counters: cnt (width clog2(CLKS_PER_BIT)) and bit_idx (3 bits). H = CLKS_PER_BIT/2.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: cnt=0, bit_idx=0. If rx_s==0, go to START.
- START: cnt increments. At cnt==H-1:
  - if rx_s==0, go to DATA with cnt=0;
  - else it is a false start: go to IDLE, with no outputs changed.
- DATA: cnt increments. At cnt==C-1 (C=CLKS_PER_BIT):
  - shift rx_s in (shift_reg <= {rx_s, shift_reg[7:1]}), cnt=0, bit_idx++;
  - after the sample with bit_idx==7, go to PARITY.
- PARITY: at cnt==C-1, store rx_s as p_rx, cnt=0, go to STOP.
- STOP: at cnt==C-1, register all outputs in the same edge:
  - data_out <= shift_reg;
  - parity_err <= p_rx ^ (^shift_reg);
  - frame_err <= ~rx_s;
  - data_valid <= 1.
  - Then go to IDLE if rx_s==1, else go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. No start detection occurs while in BREAK.
- data_valid is asserted even when parity_err or frame_err is set. The flags accompany the byte; the byte is not discarded.
- Back-to-back frames need no idle gap. A start bit following the stop sample is detected from IDLE on the next cycle.

## Timing
- Reset (rst low, async): state=IDLE, cnt=0, bit_idx=0, shift_reg=0, s1=rx_s=1, data_out=0x00, data_valid=0, parity_err=0, frame_err=0, busy=0. Reset asserted mid-frame aborts the frame with no data_valid.
- Let E0 be the first clk edge at which s1 captures rx=0. Then:
  - rx_s=0 after E1; IDLE→START at E2;
  - start bit confirmed at E(2+H);
  - data bit k sampled at E(2+H+(k+1)C), k=0..7;
  - parity sampled at E(2+H+9C);
  - stop sampled and outputs registered at E(2+H+10C).
- data_valid is high for exactly the cycle following E(2+H+10C). With C=16, that is E170.
- busy rises after E2 and falls after the stop edge, or after leaving BREAK.
- A glitch shorter than H cycles on an idle line is rejected as a false start.
- cnt never exceeds C-1. bit_idx wraps 7→0 on the transition into PARITY.

## Test plan
- Reset: hold rst=0 with rx toggling → all outputs 0, busy=0. Release rst with rx=1 → no data_valid for 200 cycles.
- Single frame 0xA5 (C=16), parity bit 0, stop 1 → data_valid pulse of exactly one cycle at E170, data_out=0xA5, parity_err=0, frame_err=0.
- Frame 0x01 sent with parity bit 0 (wrong) → data_out=0x01, parity_err=1, frame_err=0.
- Frame 0x3C with stop bit 0 and the line held low for 40 cycles → data_valid with frame_err=1. busy stays high until rx_s returns to 1; the next frame 0x55 is received cleanly with frame_err=0.
- False start: 4-cycle low pulse on an idle line → busy high for fewer than H+2 cycles, no data_valid.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap, then rst pulsed low mid-fourth frame → three correct valid pulses spaced 11·C cycles apart, no pulse for the aborted frame, outputs 0 after reset.
